// File: rtl/br31_pkg.sv
// Shared types and defaults for the BaskinRobbins31 turn sequencer.
package br31_pkg;

    localparam int unsigned TARGET_DEF       = 31;
    localparam int unsigned MAX_STEP_DEF     = 3;
    localparam int unsigned CNT_W_DEF        = 6;
    localparam int unsigned COMP_TIMEOUT_DEF = 16;

    typedef logic [1:0] move_t;

    // Legacy-compatible state encoding kept as plain constants.
    typedef logic [1:0] br31_state_t;
    localparam br31_state_t S_IDLE   = 2'd0;
    localparam br31_state_t S_P_WAIT = 2'd1;
    localparam br31_state_t S_C_WAIT = 2'd2;
    localparam br31_state_t S_DONE   = 2'd3;

    // A move is legal when it lies in 1..max_step.
    function automatic logic move_legal(input move_t m, input int unsigned max_step);
        return (m != 2'd0) && (32'(m) <= max_step);
    endfunction

endpackage

// File: rtl/br31_turn_ctrl_if.sv
// Handshake and status bundle between the game environment and the turn sequencer.
interface br31_turn_ctrl_if
    import br31_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
);

    logic             start;
    logic             comp_first;
    logic             player_valid;
    move_t            player_move;
    logic             player_ready;
    logic             comp_req;
    logic             comp_valid;
    move_t            comp_move;
    logic [CNT_W-1:0] total;
    logic [5:0]       turn_cnt;
    move_t            last_move;
    logic             illegal_move;
    logic             comp_fault;
    logic             game_over;
    logic             player_win;

    modport master (
        output start, comp_first, player_valid, player_move, comp_valid, comp_move,
        input  player_ready, comp_req, total, turn_cnt, last_move,
               illegal_move, comp_fault, game_over, player_win
    );

    modport slave (
        input  start, comp_first, player_valid, player_move, comp_valid, comp_move,
        output player_ready, comp_req, total, turn_cnt, last_move,
               illegal_move, comp_fault, game_over, player_win
    );

endinterface

// File: rtl/br31_timeout_timer.sv
// Clear/enable cycle counter; tc is high while enabled at count COMP_TIMEOUT-1.
module br31_timeout_timer #(
    parameter int unsigned COMP_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned W = (COMP_TIMEOUT > 2) ? $clog2(COMP_TIMEOUT) : 1;
    localparam logic [W-1:0] LAST = W'(COMP_TIMEOUT - 1);

    logic [W-1:0] cnt;

    // Count while enabled; clear has priority over counting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign tc = en && (cnt == LAST);

endmodule

// File: rtl/br31_turn_ctrl.sv
// Turn sequencer: alternates player/computer moves, keeps the saturating total,
// declares the winner and substitutes move 1 when the engine stalls or misbehaves.
module br31_turn_ctrl
    import br31_pkg::*;
#(
    parameter int unsigned TARGET       = TARGET_DEF,
    parameter int unsigned MAX_STEP     = MAX_STEP_DEF,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned COMP_TIMEOUT = COMP_TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    br31_turn_ctrl_if.slave  bus
);

    localparam logic [CNT_W:0] TARGET_X = (CNT_W + 1)'(TARGET);

    br31_state_t      state;
    logic [CNT_W-1:0] total;
    logic [5:0]       turn_cnt;
    move_t            last_move;
    logic             illegal_move;
    logic             comp_fault;
    logic             player_win;

    logic             p_acc;
    logic             p_ill;
    logic             c_take;
    logic             c_fault_now;
    logic             tmo;
    move_t            mv;
    logic [CNT_W:0]   sum;
    logic             hit;

    br31_timeout_timer #(
        .COMP_TIMEOUT (COMP_TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   ((state != S_C_WAIT) || c_take),
        .en    (state == S_C_WAIT),
        .tc    (tmo)
    );

    // Decide which move (if any) is taken this cycle and whether it ends the game.
    always_comb begin
        p_acc       = (state == S_P_WAIT) && bus.player_valid &&  move_legal(bus.player_move, MAX_STEP);
        p_ill       = (state == S_P_WAIT) && bus.player_valid && !move_legal(bus.player_move, MAX_STEP);
        c_take      = (state == S_C_WAIT) && (bus.comp_valid || tmo);
        c_fault_now = c_take && !(bus.comp_valid && move_legal(bus.comp_move, MAX_STEP));
        if (p_acc) begin
            mv = bus.player_move;
        end else if (c_take && !c_fault_now) begin
            mv = bus.comp_move;
        end else begin
            mv = 2'd1;
        end
        // One extra bit so the compare never sees a wrapped sum.
        sum = {1'b0, total} + (CNT_W + 1)'(mv);
        hit = (sum >= TARGET_X);
    end

    // Game state, running count and one-cycle status pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            total        <= '0;
            turn_cnt     <= '0;
            last_move    <= '0;
            illegal_move <= 1'b0;
            comp_fault   <= 1'b0;
            player_win   <= 1'b0;
        end else begin
            illegal_move <= p_ill;
            comp_fault   <= c_fault_now;
            if (p_acc || c_take) begin
                total     <= hit ? TARGET_X[CNT_W-1:0] : sum[CNT_W-1:0];
                turn_cnt  <= turn_cnt + 6'd1;
                last_move <= mv;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        total      <= '0;
                        turn_cnt   <= '0;
                        last_move  <= '0;
                        player_win <= 1'b0;
                        state      <= bus.comp_first ? S_C_WAIT : S_P_WAIT;
                    end
                end
                S_P_WAIT: begin
                    if (p_acc) begin
                        state <= hit ? S_DONE : S_C_WAIT;
                    end
                end
                S_C_WAIT: begin
                    if (c_take) begin
                        player_win <= hit;
                        state      <= hit ? S_DONE : S_P_WAIT;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.player_ready = (state == S_P_WAIT);
    assign bus.comp_req     = (state == S_C_WAIT);
    assign bus.game_over    = (state == S_DONE);
    assign bus.total        = total;
    assign bus.turn_cnt     = turn_cnt;
    assign bus.last_move    = last_move;
    assign bus.illegal_move = illegal_move;
    assign bus.comp_fault   = comp_fault;
    assign bus.player_win   = player_win;

endmodule

// File: tb/tb_br31_turn_ctrl.sv
// Directed bench for br31_turn_ctrl with hand-computed expectations.
module tb_br31_turn_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    br31_turn_ctrl_if #(.CNT_W(6)) bus ();

    br31_turn_ctrl #(
        .TARGET       (31),
        .MAX_STEP     (3),
        .CNT_W        (6),
        .COMP_TIMEOUT (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pmove(input logic [1:0] m);
        bus.player_valid = 1'b1;
        bus.player_move  = m;
        tick();
        bus.player_valid = 1'b0;
        bus.player_move  = 2'd0;
    endtask

    task automatic cmove(input logic [1:0] m);
        bus.comp_valid = 1'b1;
        bus.comp_move  = m;
        tick();
        bus.comp_valid = 1'b0;
        bus.comp_move  = 2'd0;
    endtask

    task automatic begin_game(input logic cf);
        bus.start      = 1'b1;
        bus.comp_first = cf;
        tick();
        bus.start      = 1'b0;
        bus.comp_first = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_total"}, 32'(bus.total), 0);
        chk({tag, "_turns"}, 32'(bus.turn_cnt), 0);
        chk({tag, "_last"}, 32'(bus.last_move), 0);
        chk({tag, "_ready"}, 32'(bus.player_ready), 0);
        chk({tag, "_req"}, 32'(bus.comp_req), 0);
        chk({tag, "_ill"}, 32'(bus.illegal_move), 0);
        chk({tag, "_fault"}, 32'(bus.comp_fault), 0);
        chk({tag, "_over"}, 32'(bus.game_over), 0);
        chk({tag, "_win"}, 32'(bus.player_win), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset            = 1'b1;
        bus.start        = 1'b0;
        bus.comp_first   = 1'b0;
        bus.player_valid = 1'b0;
        bus.player_move  = 2'd0;
        bus.comp_valid   = 1'b0;
        bus.comp_move    = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        reset = 1'b0;
        tick();
        chk_all_zero("idle");

        // 1: full game, player 3 / comp 1; player closes with 2 so the computer hits 31.
        begin_game(1'b0);
        chk("t1_ready", 32'(bus.player_ready), 1);
        chk("t1_total0", 32'(bus.total), 0);
        for (int r = 0; r < 7; r++) begin
            pmove(2'd3);
            chk("t1_req", 32'(bus.comp_req), 1);
            cmove(2'd1);
        end
        chk("t1_total28", 32'(bus.total), 28);
        chk("t1_turns14", 32'(bus.turn_cnt), 14);
        pmove(2'd2);
        chk("t1_total30", 32'(bus.total), 30);
        chk("t1_over30", 32'(bus.game_over), 0);
        cmove(2'd1);
        chk("t1_total31", 32'(bus.total), 31);
        chk("t1_over", 32'(bus.game_over), 1);
        chk("t1_win", 32'(bus.player_win), 1);
        chk("t1_turns16", 32'(bus.turn_cnt), 16);
        chk("t1_last", 32'(bus.last_move), 1);

        // 2: illegal player move 0; a stray comp_valid in P_WAIT must be ignored too.
        begin_game(1'b0);
        chk("t2_clr_total", 32'(bus.total), 0);
        chk("t2_clr_win", 32'(bus.player_win), 0);
        bus.comp_valid = 1'b1;
        bus.comp_move  = 2'd2;
        pmove(2'd0);
        bus.comp_valid = 1'b0;
        chk("t2_ill", 32'(bus.illegal_move), 1);
        chk("t2_total", 32'(bus.total), 0);
        chk("t2_turns", 32'(bus.turn_cnt), 0);
        chk("t2_ready", 32'(bus.player_ready), 1);
        tick();
        chk("t2_ill_end", 32'(bus.illegal_move), 0);

        // 3: engine stalls after player move 2; fallback 1 on the 16th C_WAIT cycle.
        pmove(2'd2);
        chk("t3_total2", 32'(bus.total), 2);
        for (int i = 0; i < 15; i++) tick();
        chk("t3_wait_req", 32'(bus.comp_req), 1);
        chk("t3_wait_fault", 32'(bus.comp_fault), 0);
        chk("t3_wait_total", 32'(bus.total), 2);
        tick();
        chk("t3_fault", 32'(bus.comp_fault), 1);
        chk("t3_total3", 32'(bus.total), 3);
        chk("t3_ready", 32'(bus.player_ready), 1);
        chk("t3_last", 32'(bus.last_move), 1);
        tick();
        chk("t3_fault_end", 32'(bus.comp_fault), 0);

        // 4: climb to 29, then player 3 saturates at 31 and loses.
        for (int r = 0; r < 4; r++) begin
            pmove(2'd3);
            cmove(2'd3);
        end
        pmove(2'd1);
        cmove(2'd1);
        chk("t4_total29", 32'(bus.total), 29);
        chk("t4_turns12", 32'(bus.turn_cnt), 12);
        pmove(2'd3);
        chk("t4_sat", 32'(bus.total), 31);
        chk("t4_over", 32'(bus.game_over), 1);
        chk("t4_win", 32'(bus.player_win), 0);
        chk("t4_turns13", 32'(bus.turn_cnt), 13);
        pmove(2'd1);
        chk("t4_ign_total", 32'(bus.total), 31);
        chk("t4_ign_turns", 32'(bus.turn_cnt), 13);
        chk("t4_ign_ill", 32'(bus.illegal_move), 0);

        // 5: asynchronous reset at total 17 while waiting on the engine.
        begin_game(1'b0);
        pmove(2'd3); cmove(2'd3); pmove(2'd3); cmove(2'd3);
        pmove(2'd1); cmove(2'd2); pmove(2'd2);
        chk("t5_total17", 32'(bus.total), 17);
        chk("t5_req", 32'(bus.comp_req), 1);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("t5_async");
        @(negedge clk);
        reset = 1'b0;
        tick();
        begin_game(1'b0);
        chk("t5_restart_total", 32'(bus.total), 0);
        chk("t5_restart_ready", 32'(bus.player_ready), 1);
        pmove(2'd1);
        chk("t5_restart_move", 32'(bus.total), 1);

        // 6: computer first, mid-game start ignored, illegal engine move replaced by 1.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
        begin_game(1'b1);
        chk("t6_req", 32'(bus.comp_req), 1);
        chk("t6_total0", 32'(bus.total), 0);
        cmove(2'd2);
        chk("t6_total2", 32'(bus.total), 2);
        chk("t6_ready", 32'(bus.player_ready), 1);
        chk("t6_last", 32'(bus.last_move), 2);
        chk("t6_fault0", 32'(bus.comp_fault), 0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("t6_start_ign_ready", 32'(bus.player_ready), 1);
        chk("t6_start_ign_turns", 32'(bus.turn_cnt), 1);
        pmove(2'd1);
        cmove(2'd0);
        chk("t6_fb_total", 32'(bus.total), 4);
        chk("t6_fb_fault", 32'(bus.comp_fault), 1);
        chk("t6_fb_last", 32'(bus.last_move), 1);
        chk("t6_fb_ready", 32'(bus.player_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
